// File: rtl/asteroid_pkg.sv
// Shared constants and types for the asteroid animation sequencer.
package asteroid_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ERASE = 2'd1,
    S_MOVE  = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

endpackage

// File: rtl/asteroid_animator_if.sv
// Pixel-stream and control bundle between the animator and its neighbours.
interface asteroid_animator_if;
  logic       enable;
  logic [1:0] direction;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [7:0] pos_x;
  logic [6:0] pos_y;

  modport master (
    input  enable, direction,
    output x, y, colour, plot, busy, pos_x, pos_y
  );

  modport slave (
    output enable, direction,
    input  x, y, colour, plot, busy, pos_x, pos_y
  );
endinterface

// File: rtl/asteroid_coord_wrap.sv
// Combinational modular adder: (base + offset) mod modulus for small signed
// offsets (|offset| < modulus), used for both position steps and pixel scan.
module asteroid_coord_wrap #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]      base,
  input  logic signed [3:0] offset,
  input  logic [W-1:0]      modulus,
  output logic [W-1:0]      result
);

  logic [W+1:0] sum;
  logic [W+1:0] wrapped;

  // Widen, add, then fold back into [0, modulus) from either side.
  always_comb begin
    sum     = {2'b00, base} + {{(W-2){offset[3]}}, offset};
    wrapped = sum;
    if (sum[W+1])
      wrapped = sum + {2'b00, modulus};
    else if (sum >= {2'b00, modulus})
      wrapped = sum - {2'b00, modulus};
    result = wrapped[W-1:0];
  end

endmodule

// File: rtl/asteroid_animator.sv
// Per-asteroid animation sequencer: each frame erases the sprite, steps its
// origin one pixel with screen wrap, and redraws it as a pixel stream.
module asteroid_animator
  import asteroid_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = 833333,
  parameter logic [7:0]  START_X     = 8'd80,
  parameter logic [6:0]  START_Y     = 7'd60,
  parameter logic [15:0] SPRITE_MASK = 16'h0A63,
  parameter logic [2:0]  COLOUR      = 3'b111
) (
  input  logic                       clk,
  input  logic                       reset,
  asteroid_animator_if.master        bus
);

  localparam int unsigned CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_TICKS - 1);

  state_t        state, state_nx;
  logic [3:0]    c, c_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    pos_x, pos_x_nx;
  logic [6:0]    pos_y, pos_y_nx;
  logic [7:0]    x_q, x_nx;
  logic [6:0]    y_q, y_nx;
  logic [2:0]    colour_q, colour_nx;
  logic          plot_q, plot_nx;

  logic signed [3:0] off_x, off_y;
  logic [7:0]        wx;
  logic [6:0]        wy;

  // The two wrap adders are shared: MOVE feeds them the direction step,
  // ERASE/DRAW feed them the scan column/row offset.
  asteroid_coord_wrap #(.W(8)) u_wrap_x (
    .base    (pos_x),
    .offset  (off_x),
    .modulus (8'(SCREEN_W)),
    .result  (wx)
  );

  asteroid_coord_wrap #(.W(7)) u_wrap_y (
    .base    (pos_y),
    .offset  (off_y),
    .modulus (7'(SCREEN_H)),
    .result  (wy)
  );

  // Adder offset select by state.
  always_comb begin
    off_x = '0;
    off_y = '0;
    case (state)
      S_ERASE, S_DRAW: begin
        off_x = {2'b00, c[1:0]};
        off_y = {2'b00, c[3:2]};
      end
      S_MOVE: begin
        case (bus.direction)
          DIR_DOWN:  off_y = 4'sd1;
          DIR_UP:    off_y = -4'sd1;
          DIR_RIGHT: off_x = 4'sd1;
          DIR_LEFT:  off_x = -4'sd1;
          default:   off_x = '0;
        endcase
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx  = state;
    c_nx      = c;
    cnt_nx    = cnt;
    pos_x_nx  = pos_x;
    pos_y_nx  = pos_y;
    x_nx      = x_q;
    y_nx      = y_q;
    colour_nx = colour_q;
    plot_nx   = 1'b0;
    case (state)
      S_WAIT: begin
        if (bus.enable) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = S_ERASE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_ERASE, S_DRAW: begin
        x_nx      = wx;
        y_nx      = wy;
        colour_nx = (state == S_DRAW) ? COLOUR : COLOUR_BLACK;
        plot_nx   = SPRITE_MASK[c];
        c_nx      = c + 1'b1;
        if (c == 4'd15)
          state_nx = (state == S_ERASE) ? S_MOVE : S_WAIT;
      end
      S_MOVE: begin
        pos_x_nx = wx;
        pos_y_nx = wy;
        state_nx = S_DRAW;
      end
      default: state_nx = S_WAIT;
    endcase
  end

  // State and output registers; reset starts with a full DRAW pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_DRAW;
      c        <= '0;
      cnt      <= '0;
      pos_x    <= START_X;
      pos_y    <= START_Y;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      c        <= c_nx;
      cnt      <= cnt_nx;
      pos_x    <= pos_x_nx;
      pos_y    <= pos_y_nx;
      x_q      <= x_nx;
      y_q      <= y_nx;
      colour_q <= colour_nx;
      plot_q   <= plot_nx;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.pos_x  = pos_x;
  assign bus.pos_y  = pos_y;
  // Held low while reset is asserted so the reset-time view is idle.
  assign bus.busy   = (state != S_WAIT) && !reset;

endmodule

// File: tb/tb_asteroid_animator.sv
// Directed self-checking bench for asteroid_animator (FRAME_TICKS = 40).
module tb_asteroid_animator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m, rst_w;
  asteroid_animator_if ifm();
  asteroid_animator_if ifw();

  asteroid_animator #(
    .FRAME_TICKS (40),
    .START_X     (8'd80),
    .START_Y     (7'd60),
    .SPRITE_MASK (16'h0A63),
    .COLOUR      (3'b111)
  ) dut_m (
    .clk   (clk),
    .reset (rst_m),
    .bus   (ifm)
  );

  asteroid_animator #(
    .FRAME_TICKS (40),
    .START_X     (8'd158),
    .START_Y     (7'd0),
    .SPRITE_MASK (16'h0A63),
    .COLOUR      (3'b111)
  ) dut_w (
    .clk   (clk),
    .reset (rst_w),
    .bus   (ifw)
  );

  int checks = 0;
  int errors = 0;
  int bc     = 0;
  int nplot  = 0;
  int n      = 0;
  logic [15:0] mask = 16'h0A63;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input bit w);
    return w ? ifw.busy : ifm.busy;
  endfunction

  // One 16-cycle scan; expected pixel coordinates wrap on the 160x120 screen.
  task automatic scan(input bit w, input logic [2:0] col, input int ox, input int oy,
                      input int ncyc, input string tag);
    nplot = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (busy_of(w)) bc++;
      step();
      check({tag, "_x"},   w ? ifw.x : ifm.x,           (ox + c % 4) % 160);
      check({tag, "_y"},   w ? ifw.y : ifm.y,           (oy + c / 4) % 120);
      check({tag, "_col"}, w ? ifw.colour : ifm.colour, col);
      check({tag, "_plt"}, w ? ifw.plot : ifm.plot,     mask[c]);
      if (w ? ifw.plot : ifm.plot) nplot++;
    end
  endtask

  task automatic move_step(input bit w, input int nx, input int ny, input string tag);
    if (busy_of(w)) bc++;
    step();
    check({tag, "_plt"}, w ? ifw.plot : ifm.plot,   0);
    check({tag, "_px"},  w ? ifw.pos_x : ifm.pos_x, nx);
    check({tag, "_py"},  w ? ifw.pos_y : ifm.pos_y, ny);
  endtask

  task automatic wait_busy(input bit w, output int cnt);
    cnt = 0;
    while (!busy_of(w) && cnt < 1000) begin
      step();
      cnt++;
    end
  endtask

  // Wait + erase + move + draw, checking the whole step.
  task automatic full_step(input bit w, input int ox, input int oy, input int nx, input int ny,
                           input string tag);
    int wn;
    wait_busy(w, wn);
    check({tag, "_wait"}, wn, 40);
    bc = 0;
    scan(w, 3'b000, ox, oy, 16, {tag, "_er"});
    move_step(w, nx, ny, {tag, "_mv"});
    scan(w, 3'b111, nx, ny, 16, {tag, "_dr"});
    check({tag, "_busy33"}, bc, 33);
    check({tag, "_idle"}, busy_of(w), 0);
  endtask

  logic sticky;

  initial begin
    rst_m = 1'b1;
    rst_w = 1'b1;
    ifm.enable = 1'b1;
    ifm.direction = 2'b11;
    ifw.enable = 1'b1;
    ifw.direction = 2'b01;
    step();
    step();
    check("rst_plot", ifm.plot, 0);
    check("rst_x", ifm.x, 0);
    check("rst_y", ifm.y, 0);
    check("rst_busy", ifm.busy, 0);
    check("rst_posx", ifm.pos_x, 80);
    check("rst_posy", ifm.pos_y, 60);
    rst_m = 1'b0;
    #1;
    check("busy_after_rst", ifm.busy, 1);

    // Initial draw at (80,60).
    scan(0, 3'b111, 80, 60, 16, "init");
    check("init_nplot", nplot, 6);
    check("init_idle", ifm.busy, 0);

    // One rightward step.
    full_step(0, 80, 60, 81, 60, "right1");

    // Enable held low in WAIT: counter holds its partial count.
    repeat (10) step();
    ifm.enable = 1'b0;
    sticky = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ifm.plot || ifm.busy) sticky = 1'b1;
    end
    check("hold_quiet", sticky, 0);
    check("hold_posx", ifm.pos_x, 81);
    check("hold_posy", ifm.pos_y, 60);
    ifm.enable = 1'b1;
    wait_busy(0, n);
    check("hold_remaining", n, 30);

    // Second rightward step, reset at DRAW c = 7.
    scan(0, 3'b000, 81, 60, 16, "right2_er");
    move_step(0, 82, 60, "right2_mv");
    scan(0, 3'b111, 82, 60, 7, "right2_dr");
    rst_m = 1'b1;
    step();
    check("midrst_plot", ifm.plot, 0);
    check("midrst_posx", ifm.pos_x, 80);
    check("midrst_posy", ifm.pos_y, 60);
    rst_m = 1'b0;
    scan(0, 3'b111, 80, 60, 16, "redraw");
    check("redraw_idle", ifm.busy, 0);

    // Downward step.
    ifm.direction = 2'b00;
    full_step(0, 80, 60, 80, 61, "down1");

    // Wrap instance at (158,0): initial draw straddles the right edge.
    rst_w = 1'b0;
    scan(1, 3'b111, 158, 0, 16, "w_init");
    // Up from y=0 wraps to 119; draw rows 119,0,1,2.
    full_step(1, 158, 0, 158, 119, "w_up");
    ifw.direction = 2'b11;
    full_step(1, 158, 119, 159, 119, "w_r1");
    full_step(1, 159, 119, 0, 119, "w_r2");
    ifw.direction = 2'b10;
    full_step(1, 0, 119, 159, 119, "w_left");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asteroid_animator.md
# asteroid_animator

Per-asteroid animation sequencer that sits directly upstream of the VGA adapter's pixel-write port, replacing hand-driven pixel counting. Each frame period it erases the sprite at the current position, steps the position one pixel in the commanded direction with screen wrap-around, and redraws the sprite. Output is a one-pixel-per-cycle (x, y, colour, plot) stream on the 160x120 screen.

## Interface
- FRAME_TICKS, 833333, clk cycles per animation step (50 MHz / 60 Hz); legal range 40 or more.
- START_X, 80, x position after reset (0..159).
- START_Y, 60, y position after reset (0..119).
- SPRITE_MASK, 16'h0A63, 4x4 sprite bitmap; bit i is the pixel at column i[1:0], row i[3:2].
- COLOUR, 3'b111, draw colour; erase colour is fixed at 3'b000.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enable  in  1  1 = frame counter runs; 0 = hold in WAIT once the current pass finishes.
- direction  in  2  00 down (y+1), 01 up (y-1), 11 right (x+1), 10 left (x-1); sampled in MOVE only.
- x  out  8  pixel x to the VGA adapter.
- y  out  7  pixel y to the VGA adapter.
- colour  out  3  pixel colour.
- plot  out  1  write strobe for the current x/y/colour.
- busy  out  1  1 while in ERASE, MOVE or DRAW.
- pos_x  out  8  current sprite origin x (top-left).
- pos_y  out  7  current sprite origin y.

## Operation
- States: WAIT, ERASE, MOVE, DRAW.
- Reset: state = DRAW, scan counter c = 0, frame counter = 0, pos = (START_X, START_Y), x = y = colour = plot = 0, busy = 0. The first DRAW paints the initial sprite.
- WAIT: frame counter increments while enable = 1 and holds while enable = 0. At count FRAME_TICKS-1 with enable = 1, the counter clears and the FSM goes to ERASE.
- ERASE: 16 cycles, c = 0..15. Each cycle emits pixel c with colour 000 and plot = SPRITE_MASK[c]. At c = 15 the FSM goes to MOVE.
- MOVE: 1 cycle with plot = 0. Updates pos from direction with wrap: x 159+1 = 0, 0-1 = 159; y 119+1 = 0, 0-1 = 119. Goes to DRAW.
- DRAW: identical scan to ERASE with colour = COLOUR. At c = 15 the FSM goes to WAIT.
- Pixel address: x = (pos_x + c[1:0]) mod 160 and y = (pos_y + c[3:2]) mod 120. A sprite straddling an edge is split across both edges. Compute with widened arithmetic, then subtract the screen size if the sum is at or above it.
- Deasserting enable never aborts ERASE, MOVE or DRAW.
- Reset asserted mid-pass abandons the pass immediately; the erased or half-drawn pixels are left on screen.

## Timing
- x, y, colour and plot are registered: the values for scan cycle c appear on the clock edge ending that cycle. The downstream adapter samples them on the following edge.
- Pass length is 16 + 1 + 16 = 33 cycles. busy is high for exactly 33 consecutive cycles per step, combinational from state.
- plot is high only in ERASE/DRAW cycles whose mask bit is set. It is 0 in WAIT, in MOVE, and on the first cycle after reset.
- pos_x and pos_y change only on the MOVE edge. They are stable throughout DRAW and WAIT.
- Step period with enable continuously high is FRAME_TICKS + 33 cycles.

## Structure
- Shared package asteroid_pkg holds: SCREEN_W = 160, SCREEN_H = 120, direction encodings DIR_DOWN/DIR_UP/DIR_RIGHT/DIR_LEFT, COLOUR_BLACK, and the state enum.
- Sub-module asteroid_coord_wrap is a combinational modular adder (base, signed offset, modulus) used for both the MOVE update and the pixel address. Instantiate one for x and one for y.

## Test plan
Use FRAME_TICKS = 40 for all scenarios.
- Reset, then release with enable = 1 -> the first 16 cycles emit DRAW pixels at (80..83, 60..63). plot matches 0x0A63 (6 plots: (0,0)(1,0)(1,1)(2,1)(1,2)(3,2) offsets) with colour 111. Then busy = 0.
- enable = 1, direction = 11 -> after 40 WAIT cycles: ERASE at origin (80,60) with colour 000, MOVE, then DRAW at origin (81,60). busy is high for exactly 33 cycles.
- Wrap: START_X = 158, direction = 11 -> the DRAW scan emits x values 158, 159, 0, 1. After two steps pos_x = 0. Then direction = 10 -> pos_x = 159.
- Wrap in y: START_Y = 0, direction = 01 -> after one step pos_y = 119 and the DRAW scan y values are 119, 0, 1, 2.
- Hold enable = 0 in WAIT for 200 cycles -> plot stays 0 and pos is unchanged. Release -> ERASE starts after the remaining frame count (the counter held, not reset).
- Assert reset at DRAW c = 7 -> next cycle: plot = 0, pos = (START_X, START_Y), and a fresh full 16-cycle DRAW follows.
